// File: rtl/bce_unit.sv
// rtl/bce_unit.sv - branch condition evaluator with registered result copy
module bce_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   bf,
  input  logic         en,
  output logic         bcres,
  output logic         bcres_q,
  output logic         bf_valid
);

  logic neg;
  logic zero;
  logic eq;

  assign neg  = a[N-1];
  assign zero = (a == '0);
  assign eq   = (a == b);

  // bf[0] is a don't-care for the 1xxx group, so only bf[3:1] selects there.
  always_comb begin
    bcres    = 1'b0;
    bf_valid = 1'b0;
    if (bf[3]) begin
      bf_valid = 1'b1;
      case (bf[2:1])
        2'b00:   bcres = eq;
        2'b01:   bcres = ~eq;
        2'b10:   bcres = neg | zero;
        default: bcres = ~neg & ~zero;
      endcase
    end else if (bf[3:1] == 3'b001) begin
      bf_valid = 1'b1;
      bcres    = bf[0] ? ~neg : neg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcres_q <= 1'b0;
    end else if (en) begin
      bcres_q <= bcres;
    end
  end

endmodule

// File: tb/tb_bce_unit.sv
// tb/tb_bce_unit.sv - self-checking bench for bce_unit
module tb_bce_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  bf;
  logic        en;
  logic        bcres;
  logic        bcres_q;
  logic        bf_valid;

  int checks = 0;
  int errors = 0;

  bce_unit #(.N(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .bf       (bf),
    .en       (en),
    .bcres    (bcres),
    .bcres_q  (bcres_q),
    .bf_valid (bf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: branch conditions as signed comparisons against zero.
  function automatic logic ref_taken(input logic [31:0] ra, input logic [31:0] rb, input logic [3:0] rbf);
    int sa;
    sa = $signed(ra);
    case (rbf)
      4'd2:          return sa < 0;
      4'd3:          return sa >= 0;
      4'd8, 4'd9:    return ra == rb;
      4'd10, 4'd11:  return ra != rb;
      4'd12, 4'd13:  return sa <= 0;
      4'd14, 4'd15:  return sa > 0;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic ref_valid(input logic [3:0] rbf);
    return (rbf == 4'd2) || (rbf == 4'd3) || (rbf >= 4'd8);
  endfunction

  task automatic comb_case(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic [3:0] tbf, input logic exp);
    a  = ta;
    b  = tb;
    bf = tbf;
    #1;
    check(tag, {31'd0, bcres}, {31'd0, exp});
  endtask

  logic prev;
  int   mode;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    bf    = '0;

    comb_case("bltz_neg",  32'h80000000, 32'h0, 4'b0010, 1'b1);
    comb_case("bgez_neg",  32'h80000000, 32'h0, 4'b0011, 1'b0);
    comb_case("bgez_zero", 32'h0,        32'h0, 4'b0011, 1'b1);
    comb_case("beq_1000",  32'h1234ABCD, 32'h1234ABCD, 4'b1000, 1'b1);
    comb_case("beq_1001",  32'h1234ABCD, 32'h1234ABCD, 4'b1001, 1'b1);
    comb_case("bne_eq",    32'h1234ABCD, 32'h1234ABCD, 4'b1010, 1'b0);
    comb_case("bne_diff",  32'h1234ABCD, 32'h1234ABCC, 4'b1011, 1'b1);
    comb_case("blez_zero", 32'h0, 32'h5, 4'b1100, 1'b1);
    comb_case("bgtz_zero", 32'h0, 32'h5, 4'b1110, 1'b0);
    comb_case("blez_one",  32'h1, 32'h5, 4'b1101, 1'b0);
    comb_case("bgtz_one",  32'h1, 32'h5, 4'b1111, 1'b1);
    comb_case("blez_m1",   32'hFFFFFFFF, 32'h0, 4'b1100, 1'b1);
    comb_case("bgtz_m1",   32'hFFFFFFFF, 32'h0, 4'b1110, 1'b0);

    for (int i = 0; i < 16; i++) begin
      a  = '0;
      b  = '0;
      bf = 4'(i);
      #1;
      check($sformatf("valid_bf%0d", i), {31'd0, bf_valid}, {31'd0, ref_valid(4'(i))});
      if (!ref_valid(4'(i)))
        check($sformatf("undef_bf%0d", i), {31'd0, bcres}, 32'd0);
    end

    // Register path
    repeat (2) @(posedge clk);
    #1;
    check("q_reset", {31'd0, bcres_q}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    bf    = 4'b0011;
    a     = 32'd5;
    @(posedge clk);
    #1;
    check("q_load", {31'd0, bcres_q}, 32'd1);
    en = 1'b0;
    a  = 32'h80000001;
    @(posedge clk);
    #1;
    check("q_hold", {31'd0, bcres_q}, 32'd1);
    check("comb_neg_while_hold", {31'd0, bcres}, 32'd0);
    a     = 32'd7;
    rst_n = 1'b0;
    en    = 1'b1;
    @(posedge clk);
    #1;
    check("q_reset_over_en", {31'd0, bcres_q}, 32'd0);
    check("comb_during_reset", {31'd0, bcres}, 32'd1);
    rst_n = 1'b1;

    // Random
    a    = $urandom;
    b    = $urandom;
    bf   = 4'($urandom_range(0, 15));
    #1;
    prev = ref_taken(a, b, bf);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      check("rand_q", {31'd0, bcres_q}, {31'd0, prev});
      mode = $urandom_range(0, 3);
      case (mode)
        0:       a = '0;
        1:       a = 32'($urandom_range(0, 3)) - 32'd1;
        default: a = $urandom;
      endcase
      b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      bf = 4'($urandom_range(0, 15));
      #1;
      check("rand_bcres", {31'd0, bcres}, {31'd0, ref_taken(a, b, bf)});
      check("rand_valid", {31'd0, bf_valid}, {31'd0, ref_valid(bf)});
      prev = ref_taken(a, b, bf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bce_unit.md
# bce_unit

Branch condition evaluator for the pipelined MIPS core. Compares operands `a`/`b` under the 4-bit branch function code `bf` and produces the branch-taken flag `bcres` combinationally, for same-cycle use in the decode stage. A registered copy is also provided for pipeline stages that sample the result one cycle later. The block contains no other state.

## Interface
Parameters:
- `N`, default 32: operand width in bits; must be ≥ 2.

Ports:
- `clk`, input, 1: clock. One clock, rising-edge; used only by the registered copy.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `a`, input, N: first operand, two's complement; `a[N-1]` is its sign bit.
- `b`, input, N: second operand; used only by the equality codes.
- `bf`, input, 4: branch function code.
- `en`, input, 1: load enable for the registered copy.
- `bcres`, output, 1: combinational branch-taken result.
- `bcres_q`, output, 1: registered copy of `bcres`.
- `bf_valid`, output, 1: combinational flag; 1 when `bf` is a defined branch code.

## Operation
Define `neg = a[N-1]` and `zero = (a == 0)`, with `zero` computed over all N bits. Table of `bf` codes and `bcres`:
- `0010` (bltz): `bcres = neg`.
- `0011` (bgez): `bcres = ~neg`.
- `1000` or `1001` (beq): `bcres = (a == b)`, full N-bit compare.
- `1010` or `1011` (bne): `bcres = (a != b)`.
- `1100` or `1101` (blez): `bcres = neg | zero`.
- `1110` or `1111` (bgtz): `bcres = ~neg & ~zero`.
- All other codes (`0000`, `0001`, `01xx`): `bcres = 0`.

Further rules:
- `bf[0]` is ignored for codes `1xxx`.
- `b` is ignored for every code except beq/bne.
- `bf_valid = 1` for `0010`, `0011` and every `1xxx` code; otherwise 0.
- `bcres` and `bf_valid` are purely combinational and never X when the inputs are known.
- The block performs no arithmetic. Comparisons are bitwise equality and sign/zero tests only, so there is no overflow case.

## Timing
- `bcres` and `bf_valid`: zero latency, valid within the same cycle as the inputs. Reset does not affect them.
- `bcres_q`, on each rising `clk`:
  - `rst_n = 0`: `bcres_q` is cleared to 0. Reset has priority over `en`.
  - else if `en = 1`: `bcres_q` takes the current `bcres`.
  - else: `bcres_q` holds its value.
- Reset value of `bcres_q` is 0. Asserting reset mid-operation clears `bcres_q` on the next edge only; `bcres` is unaffected.
- There is no handshake. Inputs may change every cycle.

## Test plan
- Sign codes, N=32:
  - `a=32'h80000000`, `bf=0010` -> `bcres=1`.
  - Same `a`, `bf=0011` -> `bcres=0`.
  - `a=0`, `bf=0011` -> `bcres=1`.
- Equality codes:
  - `a=b=32'h1234ABCD`, `bf=1000` and `bf=1001` -> `bcres=1`.
  - `bf=1010` -> `bcres=0`.
  - `b=32'h1234ABCC`, `bf=1011` -> `bcres=1`.
- blez/bgtz boundaries:
  - `a=0`: `bf=1100` -> 1; `bf=1110` -> 0.
  - `a=1`: `bf=1101` -> 0; `bf=1111` -> 1.
  - `a=32'hFFFFFFFF`: `bf=1100` -> 1; `bf=1110` -> 0.
- Undefined codes: `bf` in {`0000`, `0001`, `0100`–`0111`} with `a=b=0` -> `bcres=0` and `bf_valid=0`. For defined codes, `bf_valid=1`.
- Register path:
  - Hold `rst_n=0` for 2 edges -> `bcres_q=0`.
  - Release with `en=1`, `bf=0011`, `a=5` -> `bcres_q=1` after one edge.
  - Set `en=0` and change `a` to negative -> `bcres_q` stays 1.
  - Assert `rst_n=0` with `en=1` -> `bcres_q=0` on the next edge.
- Random: 1000 cycles of random `a`, `b`, `bf` with `en=1`. Check `bcres` combinationally against the table above, and check `bcres_q` equals the previous cycle's `bcres`.
